shift_seq: RTL
==============

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter AMT_W, default 4, width of the requested shift amount (maximum amount 2^AMT_W-1).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  command request; sampled only in IDLE.
REQ-005 cmd_op  input  3  shift kind: 001 LSL, 010 LSR, 100 ASR; any other code is pass-through.
REQ-006 cmd_amt  input  AMT_W  total shift distance in bits.
REQ-007 cmd_data  input  8  operand.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-010 result  output  8  current shifter8 register contents (d_out).

Function
REQ-011 The block SHALL sequence one internal shifter8 instance; shifter8 op encoding: 000 hold, 001 LSL, 010 LSR, 100 ASR, 111 LOAD; per-cycle shamt is 0-3.
REQ-012 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE: shifter op=000; start=1 at an edge latches cmd_op, cmd_amt and cmd_data, then moves to LOAD.
REQ-014 LOAD: shifter op=111, d_in=latched data; next state is SHIFT if rem>0 and the op is legal, otherwise DONE.
REQ-015 SHIFT: shifter op=latched op, shamt=min(rem,3); rem <= rem-shamt at each edge; exit to DONE on the edge where rem reaches 0.
REQ-016 The block SHALL never drive a shift op with shamt=0.
REQ-017 DONE: shifter op=000, done=1 for exactly one cycle, then IDLE.
REQ-018 Latency: with the edge that samples start as edge 0, done SHALL be high in cycle 2+ceil(amt/3), i.e. 2 + the number of SHIFT cycles.
REQ-019 result SHALL equal the operand shifted by the full cmd_amt: LSL/LSR zero-fill, ASR sign-fill; amounts of 8 or more give 0x00 (LSL/LSR) or the sign fill (ASR).
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 A new start sampled in IDLE the cycle after DONE SHALL be accepted normally; there is no dead cycle beyond DONE.
REQ-022 Changes to cmd_* after acceptance SHALL not affect the running command.
REQ-023 Pass-through (illegal cmd_op or cmd_amt=0) SHALL take the LOAD->DONE path, with result=cmd_data.
REQ-024 result SHALL hold its value in IDLE until the next LOAD.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, rem=0, the latched command to 0, and result=0x00 (shifter8 shares reset_n).
REQ-026 Reset asserted mid-command SHALL abort it with no done pulse; after release the block idles until the next start.

Structure
REQ-027 A shared package SHALL hold the shifter op constants (OP_NOP, OP_LSL, OP_LSR, OP_ASR, OP_LOAD) and the FSM state encoding.
REQ-028 shift_seq SHALL contain exactly one sub-module, shifter8, with ports clk, reset_n, op[2:0], shamt[1:0], d_in[7:0] and d_out[7:0].
REQ-029 The remaining-amount counter and the latched command SHALL be local registers, with no further sub-modules.

Verification
REQ-030 LSL, amt=5, data 0x0F -> two SHIFT cycles (shamt 3, then 2); done in cycle 4; result 0xE0.
REQ-031 LSR, amt=8, data 0xFF -> shamt 3,3,2; done in cycle 5; result 0x00.
REQ-032 ASR, amt=4, data 0x90 -> result 0xF9; ASR, amt=7, data 0x80 -> result 0xFF.
REQ-033 amt=0 or cmd_op=011, data 0xA5 -> no SHIFT state; done in cycle 2; result 0xA5.
REQ-034 start pulsed repeatedly while busy -> exactly one done per accepted command, and back-to-back commands accepted the cycle after DONE.
REQ-035 reset_n dropped during SHIFT -> busy, done and result equal 0 asynchronously; no done follows; the next command completes correctly.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: shifter8 op codes, the
// sequencer state encoding and a helper that classifies command ops.
package shift_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b111;

  // Largest distance shifter8 can move in a single cycle.
  localparam int unsigned MAX_STEP = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Only these three command codes shift; everything else passes the
  // operand through untouched.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_seq_shifter8.sv
// shifter8: 8-bit register that shifts by 0..3 bits per cycle or loads.
// Ports:
//   clk, reset_n   clock, async active-low reset (clears d_out)
//   op[2:0]        000 hold, 001 LSL, 010 LSR, 100 ASR, 111 LOAD, others hold
//   shamt[1:0]     per-cycle shift distance
//   d_in[7:0]      value captured on LOAD
//   d_out[7:0]     register contents
module shifter8
  import shift_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] op,
  input  logic [1:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out
);

  logic [7:0] d_out_q;
  logic [7:0] d_out_d;

  always_comb begin
    d_out_d = d_out_q;
    case (op)
      OP_LSL:  d_out_d = d_out_q << shamt;
      OP_LSR:  d_out_d = d_out_q >> shamt;
      OP_ASR:  d_out_d = $signed(d_out_q) >>> shamt;
      OP_LOAD: d_out_d = d_in;
      default: d_out_d = d_out_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_out_q <= 8'h00;
    else          d_out_q <= d_out_d;
  end

  assign d_out = d_out_q;

endmodule

// File: rtl/shift_seq.sv
// shift_seq: runs a multi-bit shift command on shifter8, at most 3 bits
// per cycle, and pulses done when the result is ready.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   start          command request, only looked at in IDLE
//   cmd_op[2:0]    001 LSL, 010 LSR, 100 ASR, anything else passes through
//   cmd_amt        total shift distance
//   cmd_data[7:0]  operand
//   busy           high whenever not IDLE
//   done           one-cycle pulse, result valid in that cycle
//   result[7:0]    shifter8 contents (held in IDLE)
//
// state  | meaning
// IDLE   | waiting for start; shifter holds last result
// LOAD   | operand loaded into shifter8
// SHIFT  | shifting by min(rem,3) each cycle until rem hits 0
// DONE   | result valid, done pulse
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [7:0]       cmd_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [7:0]       data_q, data_d;

  logic [2:0]       sh_op;
  logic [1:0]       sh_shamt;
  logic [7:0]       sh_din;
  logic [7:0]       sh_dout;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    data_d   = data_q;
    sh_op    = OP_NOP;
    sh_shamt = 2'd0;
    sh_din   = data_q;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = cmd_op;
          rem_d   = cmd_amt;
          data_d  = cmd_data;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        sh_op = OP_LOAD;
        if ((rem_q != '0) && is_shift_op(op_q)) begin
          state_d = ST_SHIFT;
        end else begin
          // Pass-through: nothing left to shift, so drop any stale amount.
          rem_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_SHIFT: begin
        // rem is never 0 here, so shamt is never 0 with a shift op.
        sh_op    = op_q;
        sh_shamt = (rem_q >= AMT_W'(MAX_STEP)) ? 2'd3 : rem_q[1:0];
        rem_d    = rem_q - AMT_W'(sh_shamt);
        if (rem_d == '0) state_d = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      rem_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  shifter8 u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (sh_op),
    .shamt   (sh_shamt),
    .d_in    (sh_din),
    .d_out   (sh_dout)
  );

  assign busy   = (state_q != ST_IDLE);
  assign result = sh_dout;

endmodule
